// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel store between the GPU (back bank) and the VGA adapter (front bank).
// Optional back-bank fill engine enabled by defining FRAME_BUFFER_CLEAR_EN.
//
// state       | meaning
// S_IDLE      | accepting GPU writes, swap and clear requests
// S_CLEAR     | fill engine writing clear colour to back bank (FRAME_BUFFER_CLEAR_EN only)
// S_SWAP_WAIT | swap pending, committed on next vga_frame_start
module frame_buffer_dbl #(
   parameter int PIXEL_BITS = 4,
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int ADDR_BITS  = 17
) (
   input  logic                  gpu_clk,
   input  logic                  gpu_rst,
   input  logic [PIXEL_BITS-1:0] gpu_pixel_input,
   input  logic [ADDR_BITS-1:0]  gpu_pixel_addr,
   input  logic                  gpu_we,
   output logic                  gpu_ready,
   input  logic                  swap_req,
   output logic                  swap_done,
   input  logic                  clear_req,
   input  logic [PIXEL_BITS-1:0] clear_color,
   output logic                  clear_done,
   input  logic [ADDR_BITS-1:0]  vga_pixel_addr,
   output logic [PIXEL_BITS-1:0] vga_pixel_output,
   input  logic                  vga_frame_start,
   output logic                  front_bank
);
   localparam int DEPTH    = WIDTH * HEIGHT;
   localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // one extra bit so DEPTH == 2**ADDR_BITS still compares correctly
   localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

`ifdef FRAME_BUFFER_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_SWAP_WAIT = 2'd2} state_t;
   localparam logic [ADDR_BITS-1:0] FILL_LAST = ADDR_BITS'(DEPTH - 1);
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWAP_WAIT = 2'd2} state_t;
`endif

   state_t state, state_nxt;
   logic   commit;

   logic                  wr_en;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [PIXEL_BITS-1:0] wr_data;

   logic [PIXEL_BITS-1:0] bank0 [DEPTH];
   logic [PIXEL_BITS-1:0] bank1 [DEPTH];

`ifdef FRAME_BUFFER_CLEAR_EN
   logic                  start_clear;
   logic                  clear_last;
   logic                  swap_latched;
   logic [ADDR_BITS-1:0]  fill_cnt;
   logic [PIXEL_BITS-1:0] clear_col;
`else
   logic unused_clear;
   assign unused_clear = ^{clear_req, clear_color};
   assign clear_done   = 1'b0;
`endif

   assign gpu_ready = (state == S_IDLE) && !gpu_rst;

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
      start_clear = 1'b0;
      clear_last  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
`ifdef FRAME_BUFFER_CLEAR_EN
            if (clear_req) begin
               state_nxt   = S_CLEAR;
               start_clear = 1'b1;
            end else if (swap_req) begin
               state_nxt = S_SWAP_WAIT;
            end
`else
            if (swap_req) state_nxt = S_SWAP_WAIT;
`endif
         end
`ifdef FRAME_BUFFER_CLEAR_EN
         S_CLEAR: begin
            if (fill_cnt == FILL_LAST) begin
               clear_last = 1'b1;
               state_nxt  = swap_latched ? S_SWAP_WAIT : S_IDLE;
            end
         end
`endif
         S_SWAP_WAIT: begin
            if (vga_frame_start) begin
               commit    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = gpu_pixel_addr;
      wr_data = gpu_pixel_input;
      if (gpu_ready && gpu_we && ({1'b0, gpu_pixel_addr} < DEPTH_W)) wr_en = 1'b1;
`ifdef FRAME_BUFFER_CLEAR_EN
      if ((state == S_CLEAR) && !gpu_rst) begin
         wr_en   = 1'b1;
         wr_addr = fill_cnt;
         wr_data = clear_col;
      end
`endif
   end

   always_ff @(posedge gpu_clk) begin
      if (gpu_rst) begin
         state      <= S_IDLE;
         front_bank <= 1'b0;
         swap_done  <= 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
         clear_done   <= 1'b0;
         swap_latched <= 1'b0;
         fill_cnt     <= '0;
         clear_col    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         swap_done <= commit;
         if (commit) front_bank <= ~front_bank;
`ifdef FRAME_BUFFER_CLEAR_EN
         clear_done <= clear_last;
         if (commit) swap_latched <= 1'b0;
         if (start_clear) begin
            fill_cnt     <= '0;
            clear_col    <= clear_color;
            swap_latched <= swap_req;
         end else if (clear_last) begin
            fill_cnt <= '0;
         end else if (state == S_CLEAR) begin
            fill_cnt <= fill_cnt + ADDR_BITS'(1);
         end
`endif
      end
   end

   // storage is deliberately not reset
   always_ff @(posedge gpu_clk) begin
      if (wr_en && front_bank)  bank0[wr_addr[IDX_BITS-1:0]] <= wr_data;
      if (wr_en && !front_bank) bank1[wr_addr[IDX_BITS-1:0]] <= wr_data;
   end

   always_ff @(posedge gpu_clk) begin
      if (gpu_rst)
         vga_pixel_output <= '0;
      else if ({1'b0, vga_pixel_addr} >= DEPTH_W)
         vga_pixel_output <= '0;
      else if (front_bank)
         vga_pixel_output <= bank1[vga_pixel_addr[IDX_BITS-1:0]];
      else
         vga_pixel_output <= bank0[vga_pixel_addr[IDX_BITS-1:0]];
   end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Directed bench for frame_buffer_dbl at WIDTH=4, HEIGHT=2 (DEPTH=8), ADDR_BITS=4, PIXEL_BITS=4.
// Clear scenarios run when FRAME_BUFFER_CLEAR_EN is defined; otherwise clear_req must be ignored.
module tb_frame_buffer_dbl;
   logic       gpu_clk = 1'b0;
   logic       gpu_rst = 1'b1;
   logic [3:0] gpu_pixel_input = '0;
   logic [3:0] gpu_pixel_addr = '0;
   logic       gpu_we = 1'b0;
   logic       gpu_ready;
   logic       swap_req = 1'b0;
   logic       swap_done;
   logic       clear_req = 1'b0;
   logic [3:0] clear_color = '0;
   logic       clear_done;
   logic [3:0] vga_pixel_addr = '0;
   logic [3:0] vga_pixel_output;
   logic       vga_frame_start = 1'b0;
   logic       front_bank;

   int   checks = 0;
   int   failures = 0;
   logic exp_front = 1'b0;

   frame_buffer_dbl #(.PIXEL_BITS(4), .WIDTH(4), .HEIGHT(2), .ADDR_BITS(4)) dut (
      .gpu_clk(gpu_clk), .gpu_rst(gpu_rst),
      .gpu_pixel_input(gpu_pixel_input), .gpu_pixel_addr(gpu_pixel_addr),
      .gpu_we(gpu_we), .gpu_ready(gpu_ready),
      .swap_req(swap_req), .swap_done(swap_done),
      .clear_req(clear_req), .clear_color(clear_color), .clear_done(clear_done),
      .vga_pixel_addr(vga_pixel_addr), .vga_pixel_output(vga_pixel_output),
      .vga_frame_start(vga_frame_start), .front_bank(front_bank)
   );

   always #5 gpu_clk = ~gpu_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge gpu_clk);
      #1;
   endtask

   task automatic write_px(input int a, input int d);
      gpu_we = 1'b1;
      gpu_pixel_addr = 4'(a);
      gpu_pixel_input = 4'(d);
      step();
      gpu_we = 1'b0;
   endtask

   task automatic read_px(input string tag, input int a, input int e);
      vga_pixel_addr = 4'(a);
      step();
      check(tag, 32'(vga_pixel_output), 32'(e));
   endtask

   task automatic do_swap();
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check("swap_wait_ready", 32'(gpu_ready), 32'd0);
      vga_frame_start = 1'b1;
      step();
      vga_frame_start = 1'b0;
      exp_front = ~exp_front;
      check("swap_done_pulse", 32'(swap_done), 32'd1);
      check("front_after_swap", 32'(front_bank), 32'(exp_front));
      step();
      check("swap_done_clear", 32'(swap_done), 32'd0);
      check("ready_after_swap", 32'(gpu_ready), 32'd1);
   endtask

   initial begin
      // reset
      step();
      check("rst_ready_low", 32'(gpu_ready), 32'd0);
      check("rst_front", 32'(front_bank), 32'd0);
      check("rst_vga_out", 32'(vga_pixel_output), 32'd0);
      check("rst_swap_done", 32'(swap_done), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      gpu_rst = 1'b0;
      step();
      check("ready_after_rst", 32'(gpu_ready), 32'd1);

      // fill bank1 with i+8, swap it to the front, read it all back
      for (int i = 0; i < 8; i++) write_px(i, i + 8);
      do_swap();
      for (int i = 0; i < 8; i++) read_px("bank1_pattern", i, i + 8);

      // back is bank0: zero it, mark addr 3 and 4, attempt out-of-range write to 9
      for (int i = 0; i < 8; i++) write_px(i, 0);
      write_px(3, 'hA);
      write_px(4, 'h6);
      write_px(9, 'hF);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      for (int k = 0; k < 5; k++) read_px("pre_commit_old_bank", 3, 'hB);
      vga_frame_start = 1'b1;
      vga_pixel_addr = 4'd3;
      step();
      vga_frame_start = 1'b0;
      exp_front = ~exp_front;
      check("commit_edge_old_read", 32'(vga_pixel_output), 32'hB);
      check("commit_swap_done", 32'(swap_done), 32'd1);
      check("commit_front", 32'(front_bank), 32'(exp_front));
      step();
      check("post_commit_new_read", 32'(vga_pixel_output), 32'hA);
      check("commit_swap_done_clr", 32'(swap_done), 32'd0);
      read_px("oob_write_dropped", 1, 0);
      read_px("oob_read_zero", 12, 0);
      read_px("in_range_addr4", 4, 6);

      // swap wait: writes dropped, no commit without frame start
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      for (int k = 0; k < 20; k++) begin
         check("swap_wait_ready_low", 32'(gpu_ready), 32'd0);
         write_px(k % 8, 1);
      end
      check("swap_wait_front_held", 32'(front_bank), 32'(exp_front));
      check("swap_wait_no_done", 32'(swap_done), 32'd0);
      vga_frame_start = 1'b1;
      step();
      vga_frame_start = 1'b0;
      exp_front = ~exp_front;
      check("late_commit_done", 32'(swap_done), 32'd1);
      check("late_commit_front", 32'(front_bank), 32'(exp_front));
      for (int i = 0; i < 8; i++) read_px("swap_wait_writes_dropped", i, i + 8);

      // frame start while idle is ignored
      vga_frame_start = 1'b1;
      step();
      vga_frame_start = 1'b0;
      check("idle_fs_front", 32'(front_bank), 32'(exp_front));
      check("idle_fs_no_done", 32'(swap_done), 32'd0);
      check("idle_fs_ready", 32'(gpu_ready), 32'd1);

`ifdef FRAME_BUFFER_CLEAR_EN
      // clear back bank (bank0) to 5; stray swap_req and frame start during fill are ignored
      clear_color = 4'h5;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      clear_color = 4'h0;
      for (int k = 0; k < 8; k++) begin
         check("clear_ready_low", 32'(gpu_ready), 32'd0);
         check("clear_done_early", 32'(clear_done), 32'd0);
         swap_req = (k == 2);
         vga_frame_start = (k == 4);
         step();
      end
      swap_req = 1'b0;
      vga_frame_start = 1'b0;
      check("clear_done_pulse", 32'(clear_done), 32'd1);
      check("clear_ready_back", 32'(gpu_ready), 32'd1);
      check("clear_front_held", 32'(front_bank), 32'(exp_front));
      step();
      check("clear_done_clear", 32'(clear_done), 32'd0);
      check("clear_swap_ignored", 32'(gpu_ready), 32'd1);
      do_swap();
      for (int i = 0; i < 8; i++) read_px("cleared_to_5", i, 5);

      // simultaneous clear+swap: fill bank1 with 3 then wait for frame start
      clear_color = 4'h3;
      clear_req = 1'b1;
      swap_req = 1'b1;
      step();
      clear_req = 1'b0;
      swap_req = 1'b0;
      for (int k = 0; k < 8; k++) step();
      check("combo_clear_done", 32'(clear_done), 32'd1);
      check("combo_in_swap_wait", 32'(gpu_ready), 32'd0);
      check("combo_no_swap_yet", 32'(swap_done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("combo_front_held", 32'(front_bank), 32'(exp_front));
         check("combo_swap_done_low", 32'(swap_done), 32'd0);
      end
      vga_frame_start = 1'b1;
      step();
      vga_frame_start = 1'b0;
      exp_front = ~exp_front;
      check("combo_swap_done", 32'(swap_done), 32'd1);
      check("combo_front", 32'(front_bank), 32'(exp_front));
      step();
      check("combo_ready", 32'(gpu_ready), 32'd1);
      for (int i = 0; i < 8; i++) read_px("combo_cleared_to_3", i, 3);

      // reset after four fill writes into bank0 (C over 5)
      clear_color = 4'hC;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int k = 0; k < 4; k++) step();
      gpu_rst = 1'b1;
      step();
      exp_front = 1'b0;
      check("midclr_rst_ready", 32'(gpu_ready), 32'd0);
      check("midclr_rst_front", 32'(front_bank), 32'd0);
      gpu_rst = 1'b0;
      step();
      check("midclr_ready", 32'(gpu_ready), 32'd1);
      for (int k = 0; k < 10; k++) begin
         check("midclr_no_done", 32'(clear_done), 32'd0);
         step();
      end
      for (int i = 0; i < 8; i++) read_px("partial_fill", i, (i < 4) ? 'hC : 5);
`else
      // without the fill engine clear_req is ignored
      clear_color = 4'h5;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      check("noclr_ready", 32'(gpu_ready), 32'd1);
      for (int k = 0; k < 10; k++) begin
         check("noclr_no_done", 32'(clear_done), 32'd0);
         step();
      end
      do_swap();
      read_px("noclr_addr0", 0, 0);
      read_px("noclr_addr3", 3, 'hA);
      read_px("noclr_addr4", 4, 6);
      gpu_rst = 1'b1;
      step();
      gpu_rst = 1'b0;
      check("late_rst_front", 32'(front_bank), 32'd0);
      check("late_rst_out", 32'(vga_pixel_output), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_buffer_dbl.md
# frame_buffer_dbl

Parametrised, double-buffered successor to the single-bank pixel store between the GPU and the VGA display adapter. It holds two full frames:
- The GPU draws into the back bank.
- The VGA adapter reads the front bank.
- A GPU swap request is committed only at the VGA frame boundary, so the display never tears.
- An optional fill engine clears the back bank to a single colour.

## Interface
Parameters:
- PIXEL_BITS, 4, bits per pixel (palette index)
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDR_BITS, 17, pixel address width; must satisfy 2**ADDR_BITS >= WIDTH*HEIGHT (DEPTH = WIDTH*HEIGHT)

Ports:
- gpu_clk  in  1  single clock for the whole block
- gpu_rst  in  1  reset, synchronous, active-high
- gpu_pixel_input  in  PIXEL_BITS  pixel value to write to back bank
- gpu_pixel_addr  in  ADDR_BITS  back-bank write address
- gpu_we  in  1  write strobe; honoured only while gpu_ready=1
- gpu_ready  out  1  block in IDLE and accepting writes/requests
- swap_req  in  1  single-cycle request to exchange banks at next frame start
- swap_done  out  1  one-cycle pulse on the edge after a swap commits
- clear_req  in  1  single-cycle request to fill back bank with clear_color
- clear_color  in  PIXEL_BITS  fill value, sampled with clear_req
- clear_done  out  1  one-cycle pulse when fill completes
- vga_pixel_addr  in  ADDR_BITS  front-bank read address
- vga_pixel_output  out  PIXEL_BITS  registered front-bank pixel
- vga_frame_start  in  1  one-cycle pulse from VGA adapter, one cycle before first pixel read of a frame
- front_bank  out  1  index of bank currently displayed

## Operation
- Storage: two arrays of DEPTH x PIXEL_BITS. Contents are not reset.
- Bank roles: front = front_bank, back = ~front_bank.
- Read path:
  - Every cycle: vga_pixel_output <= front[vga_pixel_addr].
  - vga_pixel_addr >= DEPTH reads as 0.
- Write path:
  - gpu_we && gpu_ready && gpu_pixel_addr < DEPTH writes back[gpu_pixel_addr].
  - All other writes are dropped silently.
- State machine: IDLE, CLEAR, SWAP_WAIT.
  - IDLE: gpu_ready=1.
    - clear_req -> CLEAR. The fill counter loads 0 and clear_color is latched.
    - swap_req without clear_req -> SWAP_WAIT.
    - clear_req and swap_req together -> CLEAR with swap_latched=1.
  - CLEAR:
    - Writes back[cnt] = latched colour each cycle, cnt++.
    - When cnt = DEPTH-1 is written, go to SWAP_WAIT if swap_latched, else IDLE.
    - clear_done pulses in the cycle after the last write.
    - swap_req/clear_req received in CLEAR are ignored.
  - SWAP_WAIT:
    - On vga_frame_start, front_bank toggles, swap_latched clears and the FSM goes to IDLE.
    - swap_done pulses the next cycle.
    - Requests received in SWAP_WAIT are ignored.
- The fill counter is ADDR_BITS wide and never addresses >= DEPTH.

## Timing
- Reset (one gpu_rst cycle), all applied at the edge:
  - state=IDLE, front_bank=0, vga_pixel_output=0, swap_done=0, clear_done=0, swap_latched=0, fill counter=0.
  - gpu_ready=0 while gpu_rst=1.
- Reset mid-CLEAR aborts the fill; the back bank is left partially filled. Reset in SWAP_WAIT drops the pending swap.
- Read latency: 1 cycle, address to vga_pixel_output.
- Swap commit edge:
  - The read sampled on the same edge as the commit uses the old front bank.
  - Reads from the next edge use the new one.
- Write latency: a written pixel is visible to the front only after a swap.
- Clear duration: exactly DEPTH cycles in CLEAR. With clear_req at edge t, clear_done=1 during cycle t+DEPTH+1 and gpu_ready=1 again in that same cycle.
- Swap latency: vga_frame_start at edge f gives front_bank toggled and swap_done=1 in cycle f+1.
- vga_frame_start in IDLE or CLEAR has no effect.

## Configuration
- FRAME_BUFFER_CLEAR_EN defined:
  - The CLEAR state, fill counter, clear_color latch and clear_done logic are present, as described above.
- FRAME_BUFFER_CLEAR_EN undefined:
  - No CLEAR state; clear_req and clear_color are ignored and clear_done is tied 0.
  - swap_req alone governs IDLE -> SWAP_WAIT.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 (DEPTH=8), ADDR_BITS=4, PIXEL_BITS=4.
- Reset: assert gpu_rst 1 cycle -> front_bank=0, vga_pixel_output=0, swap_done=0, clear_done=0, gpu_ready=1 the cycle after release.
- Write-swap-read:
  - Stimulus: write 0xA to addr 3, swap_req, vga_frame_start 5 cycles later, then read addr 3.
  - Required: reads before the commit show the old bank; swap_done pulses; front_bank=1; the read returns 0xA one cycle after the address.
- Swap wait:
  - Stimulus: swap_req, then gpu_we for 20 cycles with no vga_frame_start.
  - Required: gpu_ready=0, all writes dropped, front_bank unchanged.
- Clear (macro defined):
  - Stimulus: clear_req with clear_color=0x5 at edge t.
  - Required: gpu_ready=0 for 8 cycles; clear_done pulses in cycle t+9; after a swap, addrs 0-7 read 0x5.
- Simultaneous clear_req+swap_req:
  - Required: fill completes, then the FSM enters SWAP_WAIT; the swap commits only at the next vga_frame_start; clear_done precedes swap_done.
- Bounds and reset mid-clear:
  - Stimulus: write to addr 9; read addr 12; gpu_rst at clear cycle 4.
  - Required: no write occurs; the read returns 0; state=IDLE with no clear_done pulse.
